// File: rtl/exec_ctrl_pkg.sv
`timescale 1ns/1ps
// exec_ctrl_pkg
// Shared definitions for the multi-cycle execution controller and the ALU/
// register-file slice around it: FSM state encoding, opcode and extension
// field constants, ALU control codes, and the instruction decoder.
// No ports (package).
package exec_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_HALT      = 3'd4
   } state_t;

   localparam int REG_ADDR_W = 4;
   localparam int ALU_CODE_W = 6;

   // Primary opcodes, IR[15:12]
   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_XORI  = 4'b0011;
   localparam logic [3:0] OP_WAIT  = 4'b0100;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_ADDUI = 4'b0110;
   localparam logic [3:0] OP_SHIFT = 4'b1000;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_MOVI  = 4'b1101;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   // Extension field values, IR[7:4]
   localparam logic [3:0] EXT_WAIT = 4'b0000;
   localparam logic [3:0] EXT_LSH  = 4'b0100;
   localparam logic [3:0] EXT_ADD  = 4'b0101;
   localparam logic [3:0] EXT_SUB  = 4'b1001;
   localparam logic [3:0] EXT_CMP  = 4'b1011;

   // ALU control codes that are not simply {2'b00, op/ext}
   localparam logic [ALU_CODE_W-1:0] ALU_NOP = 6'b000000;
   localparam logic [ALU_CODE_W-1:0] ALU_LSH = 6'b100101;
   localparam logic [ALU_CODE_W-1:0] ALU_LUI = 6'b111111;

   // Everything the controller needs to remember about one instruction.
   // load_ops=0 means the operand registers keep their previous contents.
   typedef struct packed {
      logic [ALU_CODE_W-1:0] alu_code;
      logic                  load_ops;
      logic                  src_reg;
      logic                  sign_ext;
      logic                  reg_write;
      logic                  psr_write;
      logic                  is_wait;
   } decode_t;

   function automatic decode_t decode_instr(input logic [15:0] word);
      decode_t    d;
      logic [3:0] op;
      logic [3:0] ext;
      op  = word[15:12];
      ext = word[7:4];
      d   = '0;
      d.alu_code = ALU_NOP;
      case (op)
         OP_RTYPE: begin
            d.alu_code  = {2'b00, ext};
            d.load_ops  = 1'b1;
            d.src_reg   = 1'b1;
            d.reg_write = (ext != EXT_CMP);
            d.psr_write = (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI: begin
            d.alu_code  = {2'b00, op};
            d.load_ops  = 1'b1;
            d.reg_write = 1'b1;
         end
         OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
            d.alu_code  = {2'b00, op};
            d.load_ops  = 1'b1;
            d.sign_ext  = 1'b1;
            d.reg_write = (op != OP_CMPI);
            d.psr_write = (op != OP_MOVI);
         end
         OP_SHIFT: begin
            // Only the LSH extension is implemented; other shifts are NOPs
            if (ext == EXT_LSH) begin
               d.alu_code  = ALU_LSH;
               d.load_ops  = 1'b1;
               d.src_reg   = 1'b1;
               d.reg_write = 1'b1;
            end
         end
         OP_LUI: begin
            d.alu_code  = ALU_LUI;
            d.load_ops  = 1'b1;
            d.reg_write = 1'b1;
         end
         OP_WAIT: begin
            d.is_wait = (ext == EXT_WAIT);
         end
         default: begin
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/exec_ctrl_reg_file.sv
`timescale 1ns/1ps
// exec_ctrl_reg_file
// General register file: REG_COUNT x WIDTH, two combinational read ports,
// one synchronous write port, asynchronous active-low clear of all entries.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low clear
//   ra_addr/ra_data  read port A (combinational)
//   rb_addr/rb_data  read port B (combinational)
//   we/w_addr/w_data synchronous write port
module exec_ctrl_reg_file
   import exec_ctrl_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int REG_COUNT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] ra_addr,
   input  logic [REG_ADDR_W-1:0] rb_addr,
   output logic [WIDTH-1:0]      ra_data,
   output logic [WIDTH-1:0]      rb_data,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] w_addr,
   input  logic [WIDTH-1:0]      w_data
);

   logic [WIDTH-1:0] regs [REG_COUNT];

   // Storage: cleared as a whole by reset, otherwise one write per cycle.
   // R0 is an ordinary register here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[w_addr] <= w_data;
      end
   end

   // Reads are combinational so DECODE sees the value written by the
   // preceding WRITEBACK without any forwarding.
   always_comb begin
      ra_data = regs[ra_addr];
      rb_data = regs[rb_addr];
   end

endmodule

// File: rtl/exec_ctrl.sv
`timescale 1ns/1ps
// exec_ctrl
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller for a 16-bit
// CR16-style instruction set. It fetches from instruction memory, reads
// operands from its register file, presents them to an external ALU and
// writes back the ALU result and flags. WAIT parks it in HALT until reset.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   instr_ready  memory has a valid word on instr_data
//   instr_data   fetched instruction
//   alu_out      external ALU result (combinational from alu_a/alu_b/alu_cont)
//   psr_flags    external ALU flags {8'b0,N,Z,F,2'b0,L,1'b0,C}
//   instr_rd     fetch request (FETCH only)
//   instr_addr   program counter
//   alu_a/alu_b  registered ALU operands
//   alu_cont     registered ALU control code
//   psr          architectural flag register
//   halted       high while in HALT
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int ALU_CONT_BITS = 6,
   parameter int REG_COUNT     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     instr_ready,
   input  logic [WIDTH-1:0]         instr_data,
   input  logic [WIDTH-1:0]         alu_out,
   input  logic [WIDTH-1:0]         psr_flags,
   output logic                     instr_rd,
   output logic [WIDTH-1:0]         instr_addr,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic [ALU_CONT_BITS-1:0] alu_cont,
   output logic [WIDTH-1:0]         psr,
   output logic                     halted
);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ir;
   logic             wb_en;
   logic             psr_en;
   logic             rf_we;
   logic             psr_load;
   decode_t          dec;
   logic [WIDTH-1:0] rf_a;
   logic [WIDTH-1:0] rf_b;
   logic [WIDTH-1:0] imm_ext;

   assign dec        = decode_instr(ir[15:0]);
   assign instr_addr = pc;
   assign imm_ext    = dec.sign_ext ? {{(WIDTH-8){ir[7]}}, ir[7:0]}
                                    : {{(WIDTH-8){1'b0}}, ir[7:0]};

   exec_ctrl_reg_file #(
      .WIDTH     (WIDTH),
      .REG_COUNT (REG_COUNT)
   ) u_reg_file (
      .clk     (clk),
      .reset   (reset),
      .ra_addr (ir[11:8]),
      .rb_addr (ir[3:0]),
      .ra_data (rf_a),
      .rb_data (rf_b),
      .we      (rf_we),
      .w_addr  (ir[11:8]),
      .w_data  (alu_out)
   );

   // State register. Reset anywhere in an instruction drops straight back
   // to FETCH, so a pending writeback never happens.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control strobes. The register and PSR writes are only
   // enabled in WRITEBACK, using the enables captured during DECODE.
   always_comb begin
      next_state = state;
      instr_rd   = 1'b0;
      rf_we      = 1'b0;
      psr_load   = 1'b0;
      halted     = 1'b0;
      case (state)
         ST_FETCH: begin
            instr_rd = 1'b1;
            if (instr_ready) begin
               next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
            next_state = dec.is_wait ? ST_HALT : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            next_state = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            rf_we      = wb_en;
            psr_load   = psr_en;
            next_state = ST_FETCH;
         end
         ST_HALT: begin
            halted     = 1'b1;
            next_state = ST_HALT;
         end
         default: begin
            next_state = ST_FETCH;
         end
      endcase
   end

   // Datapath registers: instruction capture and PC increment in FETCH,
   // operand/control latching in DECODE, flag update in WRITEBACK. A NOP
   // or WAIT still clears alu_cont but leaves the operands untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= '0;
         ir       <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_cont <= '0;
         psr      <= '0;
         wb_en    <= 1'b0;
         psr_en   <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (instr_ready) begin
                  ir <= instr_data;
                  pc <= pc + {{(WIDTH-1){1'b0}}, 1'b1};
               end
            end
            ST_DECODE: begin
               alu_cont <= ALU_CONT_BITS'(dec.alu_code);
               wb_en    <= dec.reg_write;
               psr_en   <= dec.psr_write;
               if (dec.load_ops) begin
                  alu_a <= rf_a;
                  alu_b <= dec.src_reg ? rf_b : imm_ext;
               end
            end
            ST_WRITEBACK: begin
               if (psr_load) begin
                  psr <= psr_flags;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_ctrl.sv
`timescale 1ns/1ps
// tb_exec_ctrl
// Self-checking bench for exec_ctrl: a directed program with hand-derived
// expectations, hand sequences for WAIT/HALT and reset mid-instruction, and
// a randomized instruction stream checked against a behavioural ISA model.
// The bench also plays the role of the external ALU.
module tb_exec_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_ready;
   logic [15:0] instr_data;
   logic [15:0] alu_out;
   logic [15:0] psr_flags;
   logic        instr_rd;
   logic [15:0] instr_addr;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [5:0]  alu_cont;
   logic [15:0] psr;
   logic        halted;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [15:0] ins;
      int          stall;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [5:0]  ec;
      logic        ca;
      logic        cb;
      logic [15:0] epsr;
   } vec_t;

   vec_t        vecs [20];
   logic [15:0] mreg [16];
   logic [15:0] mpsr;
   logic [15:0] mpc;
   logic [3:0]  opList [13];

   exec_ctrl #(
      .WIDTH         (16),
      .ALU_CONT_BITS (6),
      .REG_COUNT     (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_ready (instr_ready),
      .instr_data  (instr_data),
      .alu_out     (alu_out),
      .psr_flags   (psr_flags),
      .instr_rd    (instr_rd),
      .instr_addr  (instr_addr),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_cont    (alu_cont),
      .psr         (psr),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // External ALU: returns {result, flags{8'b0,N,Z,F,2'b0,L,1'b0,C}}
   function automatic logic [31:0] aluRef(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] c);
      logic [16:0] wide;
      logic [15:0] r;
      logic        n, z, f, l, cy;
      r = '0; f = 1'b0; l = 1'b0; cy = 1'b0; wide = '0;
      case (c)
         6'd1:  r = a & b;
         6'd2:  r = a | b;
         6'd3:  r = a ^ b;
         6'd5, 6'd6: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[15:0];
            cy   = wide[16];
            f    = (a[15] == b[15]) && (r[15] != a[15]);
         end
         6'd9: begin
            r  = a - b;
            cy = (a < b);
            f  = (a[15] != b[15]) && (r[15] != a[15]);
         end
         6'd11: begin
            r = a - b;
            l = (a < b);
         end
         6'd13: r = b;
         6'h25: r = a << b[3:0];
         6'h3F: r = {b[7:0], 8'h00};
         default: r = '0;
      endcase
      n = r[15];
      z = (r == 16'h0000);
      if (c == 6'd11) begin
         z = (a == b);
         n = ($signed(a) < $signed(b));
      end
      return {r, 8'h00, n, z, f, 2'b00, l, 1'b0, cy};
   endfunction

   assign {alu_out, psr_flags} = aluRef(alu_a, alu_b, alu_cont);

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Runs one non-WAIT instruction from the FETCH negedge to the next FETCH
   // negedge, checking fetch, operands/control in EXECUTE and psr afterwards.
   task automatic applyStimulus(input logic [15:0] ins, input int stall,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [5:0] ec, input logic ca, input logic cb,
                                input logic [15:0] epsr, input logic [15:0] epc,
                                input string tag);
      checkOutput($sformatf("%s fetch_addr", tag), instr_addr, epc);
      checkOutput($sformatf("%s fetch_rd", tag), {15'd0, instr_rd}, 16'd1);
      for (int s = 0; s < stall; s++) begin
         instr_ready = 1'b0;
         instr_data  = 16'($urandom);
         @(negedge clk);
         checkOutput($sformatf("%s stall_rd", tag), {15'd0, instr_rd}, 16'd1);
         checkOutput($sformatf("%s stall_addr", tag), instr_addr, epc);
      end
      instr_ready = 1'b1;
      instr_data  = ins;
      @(negedge clk);
      instr_ready = 1'($urandom_range(0, 1));
      instr_data  = 16'($urandom);
      @(negedge clk);
      checkOutput($sformatf("%s alu_cont", tag), {10'd0, alu_cont}, {10'd0, ec});
      if (ca) checkOutput($sformatf("%s alu_a", tag), alu_a, ea);
      if (cb) checkOutput($sformatf("%s alu_b", tag), alu_b, eb);
      instr_ready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("%s wb_rd", tag), {15'd0, instr_rd}, 16'd0);
      @(negedge clk);
      checkOutput($sformatf("%s psr", tag), psr, epsr);
   endtask

   // ISA-level reference: operands, control code and architectural effect of
   // one instruction, straight from the instruction-set rules.
   task automatic modelStep(input logic [15:0] ins, output logic [15:0] ea,
                            output logic [15:0] eb, output logic [5:0] ec,
                            output logic ca, output logic cb,
                            output logic [15:0] epsr, output logic [15:0] epc);
      logic [3:0]  op, rd, ext, rs;
      logic [7:0]  imm;
      logic        wr, fw;
      logic [31:0] res;
      op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
      epc = mpc;
      mpc = mpc + 16'd1;
      ea = mreg[rd]; eb = '0; ec = '0; ca = 1'b1; cb = 1'b1; wr = 1'b0; fw = 1'b0;
      if (op == 4'h0) begin
         eb = mreg[rs]; ec = {2'b00, ext};
         wr = (ext != 4'hB);
         fw = (ext == 4'h5) || (ext == 4'h9) || (ext == 4'hB);
      end else if (op inside {4'h1, 4'h2, 4'h3, 4'h6}) begin
         eb = {8'h00, imm}; ec = {2'b00, op}; wr = 1'b1;
      end else if (op inside {4'h5, 4'h9, 4'hB, 4'hD}) begin
         eb = {{8{imm[7]}}, imm}; ec = {2'b00, op};
         wr = (op != 4'hB);
         fw = (op != 4'hD);
      end else if (op == 4'h8 && ext == 4'h4) begin
         eb = mreg[rs]; ec = 6'h25; wr = 1'b1;
      end else if (op == 4'hF) begin
         eb = {8'h00, imm}; ec = 6'h3F; ca = 1'b0; wr = 1'b1;
      end else begin
         ca = 1'b0; cb = 1'b0;
      end
      res = aluRef(ea, eb, ec);
      if (wr) mreg[rd] = res[31:16];
      if (fw) mpsr = res[15:0];
      epsr = mpsr;
   endtask

   function automatic logic [15:0] randInstr();
      logic [15:0] w;
      w = 16'($urandom);
      w[15:12] = opList[$urandom_range(0, 12)];
      if (w[15:12] == 4'h8 && $urandom_range(0, 1) == 1) w[7:4] = 4'h4;
      if (w[15:12] == 4'h4 && w[7:4] == 4'h0) w[7:4] = 4'h1;
      return w;
   endfunction

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 2ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] ea, eb, epsr, epc;
      logic [5:0]  ec;
      logic        ca, cb;

      reset = 1'b0; instr_ready = 1'b0; instr_data = '0;
      opList = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'h8, 4'hF, 4'h7, 4'h4};

      //          ins       stall  alu_a     alu_b     cont   ca    cb    psr after
      vecs[0]  = '{16'h5105, 0, 16'h0000, 16'h0005, 6'h05, 1'b1, 1'b1, 16'h0000}; // ADDI R1,5
      vecs[1]  = '{16'hF17F, 0, 16'h0000, 16'h007F, 6'h3F, 1'b0, 1'b1, 16'h0000}; // LUI R1,7F
      vecs[2]  = '{16'h21FF, 0, 16'h7F00, 16'h00FF, 6'h02, 1'b1, 1'b1, 16'h0000}; // ORI R1,FF
      vecs[3]  = '{16'h5201, 0, 16'h0000, 16'h0001, 6'h05, 1'b1, 1'b1, 16'h0000}; // ADDI R2,1
      vecs[4]  = '{16'h0152, 3, 16'h7FFF, 16'h0001, 6'h05, 1'b1, 1'b1, 16'h00A0}; // ADD R1,R2
      vecs[5]  = '{16'h5304, 0, 16'h0000, 16'h0004, 6'h05, 1'b1, 1'b1, 16'h0000}; // ADDI R3,4
      vecs[6]  = '{16'hB304, 0, 16'h0004, 16'h0004, 6'h0B, 1'b1, 1'b1, 16'h0040}; // CMPI R3,4
      vecs[7]  = '{16'h0363, 0, 16'h0004, 16'h0004, 6'h06, 1'b1, 1'b1, 16'h0040}; // ADDU R3,R3
      vecs[8]  = '{16'h04D3, 0, 16'h0000, 16'h0008, 6'h0D, 1'b1, 1'b1, 16'h0040}; // MOV R4,R3
      vecs[9]  = '{16'h92FF, 1, 16'h0001, 16'hFFFF, 6'h09, 1'b1, 1'b1, 16'h0001}; // SUBI R2,-1
      vecs[10] = '{16'h3280, 0, 16'h0002, 16'h0080, 6'h03, 1'b1, 1'b1, 16'h0001}; // XORI R2,80
      vecs[11] = '{16'h8243, 0, 16'h0082, 16'h0008, 6'h25, 1'b1, 1'b1, 16'h0001}; // LSH R2,R3
      vecs[12] = '{16'h7123, 0, 16'h0000, 16'h0000, 6'h00, 1'b0, 1'b0, 16'h0001}; // NOP
      vecs[13] = '{16'hD580, 0, 16'h0000, 16'hFF80, 6'h0D, 1'b1, 1'b1, 16'h0001}; // MOVI R5,-128
      vecs[14] = '{16'h5003, 0, 16'h0000, 16'h0003, 6'h05, 1'b1, 1'b1, 16'h0000}; // ADDI R0,3
      vecs[15] = '{16'h0050, 0, 16'h0003, 16'h0003, 6'h05, 1'b1, 1'b1, 16'h0000}; // ADD R0,R0
      vecs[16] = '{16'h02B5, 0, 16'h8200, 16'hFF80, 6'h0B, 1'b1, 1'b1, 16'h0084}; // CMP R2,R5
      vecs[17] = '{16'h6200, 0, 16'h8200, 16'h0000, 6'h06, 1'b1, 1'b1, 16'h0084}; // ADDUI R2,0
      vecs[18] = '{16'h06D0, 0, 16'h0000, 16'h0006, 6'h0D, 1'b1, 1'b1, 16'h0084}; // MOV R6,R0
      vecs[19] = '{16'h0461, 0, 16'h0008, 16'h8000, 6'h06, 1'b1, 1'b1, 16'h0084}; // ADDU R4,R1

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst instr_addr", instr_addr, 16'h0000);
      checkOutput("rst instr_rd", {15'd0, instr_rd}, 16'd1);
      checkOutput("rst alu_a", alu_a, 16'h0000);
      checkOutput("rst alu_b", alu_b, 16'h0000);
      checkOutput("rst alu_cont", {10'd0, alu_cont}, 16'h0000);
      checkOutput("rst psr", psr, 16'h0000);
      checkOutput("rst halted", {15'd0, halted}, 16'd0);
      reset = 1'b1;

      // Directed program
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].ins, vecs[i].stall, vecs[i].ea, vecs[i].eb, vecs[i].ec,
                       vecs[i].ca, vecs[i].cb, vecs[i].epsr, 16'(i), $sformatf("vec%0d", i));
      end

      // WAIT: halt is absorbing, no further fetches
      checkOutput("wait fetch_addr", instr_addr, 16'd20);
      instr_ready = 1'b1;
      instr_data  = 16'h4000;
      @(negedge clk);
      instr_data = 16'h5105;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("halt halted", {15'd0, halted}, 16'd1);
         checkOutput("halt instr_rd", {15'd0, instr_rd}, 16'd0);
         checkOutput("halt instr_addr", instr_addr, 16'd21);
         checkOutput("halt psr", psr, 16'h0084);
      end
      instr_ready = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("halt_rst halted", {15'd0, halted}, 16'd0);
      checkOutput("halt_rst instr_addr", instr_addr, 16'h0000);
      checkOutput("halt_rst psr", psr, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // Reset during EXECUTE of ADDI R1,-1 must abort its writeback
      instr_ready = 1'b1;
      instr_data  = 16'h51FF;
      @(negedge clk);
      instr_ready = 1'b0;
      @(negedge clk);
      checkOutput("abort alu_b", alu_b, 16'hFFFF);
      checkOutput("abort alu_cont", {10'd0, alu_cont}, 16'h0005);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checkOutput("abort psr", psr, 16'h0000);
      checkOutput("abort instr_addr", instr_addr, 16'h0000);
      applyStimulus(16'h01B1, 0, 16'h0000, 16'h0000, 6'h0B, 1'b1, 1'b1, 16'h0040,
                    16'h0000, "abort_cmp");

      // Randomized stream against the ISA model
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 16; k++) mreg[k] = '0;
      mpsr = '0;
      mpc  = '0;
      for (int n = 0; n < 300; n++) begin
         logic [15:0] ins;
         ins = randInstr();
         modelStep(ins, ea, eb, ec, ca, cb, epsr, epc);
         applyStimulus(ins, $urandom_range(0, 2), ea, eb, ec, ca, cb, epsr, epc,
                       $sformatf("rnd%0d(%h)", n, ins));
      end
      // Read every register back through alu_a with CMP Rk,Rk
      for (int k = 0; k < 16; k++) begin
         logic [15:0] ins;
         ins = {4'h0, 4'(k), 4'hB, 4'(k)};
         modelStep(ins, ea, eb, ec, ca, cb, epsr, epc);
         applyStimulus(ins, 0, ea, eb, ec, ca, cb, epsr, epc, $sformatf("sweep R%0d", k));
      end
      checkOutput("end halted", {15'd0, halted}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
